// File: rtl/pipeline_half_buffer_arbiter_pkg.sv
// Shared constants and helpers for the half-buffer round-robin arbiter.
// The optional packet lock is enabled by PIPELINE_HALF_BUFFER_ARBITER_PACKET_LOCK_EN.
package pipeline_arbiter_pkg;

  // Lock-state encoding: idle means every producer may be arbitrated.
  localparam logic LOCK_IDLE = 1'b0;
  localparam logic LOCK_HELD = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  // Pointer value after reset, so that producer 0 is scanned first.
  function automatic int unsigned reset_pointer(input int unsigned input_count);
    return input_count - 1;
  endfunction

endpackage

// File: rtl/pipeline_half_buffer_arbiter_if.sv
// Producer-side and consumer-side handshake bundle of the arbiter.
interface pipeline_half_buffer_arbiter_if #(
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned INPUT_COUNT  = 4,
  parameter int unsigned SOURCE_WIDTH = 2
);
  logic [INPUT_COUNT-1:0]            in_valid;
  logic [INPUT_COUNT-1:0]            in_ready;
  logic [INPUT_COUNT*WORD_WIDTH-1:0] in_data;
  logic [INPUT_COUNT-1:0]            in_last;
  logic                              out_valid;
  logic                              out_ready;
  logic [WORD_WIDTH-1:0]             out_data;
  logic [SOURCE_WIDTH-1:0]           out_source;
  logic                              out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_source, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_source, out_last
  );
endinterface

// File: rtl/pipeline_half_buffer_arbiter_select.sv
// Combinational round-robin scan starting just after last_grant.
module round_robin_select #(
  parameter int unsigned INPUT_COUNT  = 4,
  parameter int unsigned SOURCE_WIDTH = 2
) (
  input  logic [INPUT_COUNT-1:0]  request,
  input  logic [SOURCE_WIDTH-1:0] last_grant,
  output logic [INPUT_COUNT-1:0]  grant,
  output logic [SOURCE_WIDTH-1:0] grant_index,
  output logic                    grant_valid
);

  always_comb begin
    int unsigned idx;
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int unsigned off = 1; off <= INPUT_COUNT; off++) begin
      idx = (32'(last_grant) + off) % INPUT_COUNT;
      if (!grant_valid && request[idx]) begin
        grant[idx]  = 1'b1;
        grant_index = SOURCE_WIDTH'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_half_buffer_arbiter.sv
// Round-robin arbiter feeding one half-buffer register; in_ready never depends on out_ready.
// Optional packet lock: define PIPELINE_HALF_BUFFER_ARBITER_PACKET_LOCK_EN.
module pipeline_half_buffer_arbiter
  import pipeline_arbiter_pkg::*;
#(
  parameter int unsigned           WORD_WIDTH   = 8,
  parameter int unsigned           INPUT_COUNT  = 4,
  parameter int unsigned           SOURCE_WIDTH = 2,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE  = '0
) (
  input logic                            clock,
  input logic                            clear_n,
  pipeline_half_buffer_arbiter_if.slave  bus
);

  localparam logic [SOURCE_WIDTH-1:0] PTR_RESET = SOURCE_WIDTH'(reset_pointer(INPUT_COUNT));

  logic                    full_q;
  logic [WORD_WIDTH-1:0]   data_q;
  logic [SOURCE_WIDTH-1:0] source_q;
  logic [SOURCE_WIDTH-1:0] last_grant_q;

  logic [INPUT_COUNT-1:0]  eligible_c;
  logic [INPUT_COUNT-1:0]  req_c;
  logic [INPUT_COUNT-1:0]  grant_c;
  logic [SOURCE_WIDTH-1:0] grant_idx_c;
  logic                    grant_any_c;
  logic [WORD_WIDTH-1:0]   load_word_c;

`ifdef PIPELINE_HALF_BUFFER_ARBITER_PACKET_LOCK_EN
  logic                    lock_q;
  logic [SOURCE_WIDTH-1:0] lock_owner_q;
  logic                    last_q;
  logic                    load_last_c;

  // While a packet is open only its owner is eligible, valid or not.
  always_comb begin
    eligible_c = bus.in_valid;
    if (lock_q != LOCK_IDLE) eligible_c = bus.in_valid & (INPUT_COUNT'(1) << lock_owner_q);
  end

  always_comb begin
    load_last_c = 1'b0;
    for (int unsigned k = 0; k < INPUT_COUNT; k++)
      if (grant_c[k]) load_last_c = bus.in_last[k];
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      lock_q       <= LOCK_IDLE;
      lock_owner_q <= '0;
      last_q       <= 1'b0;
    end else if (!full_q && grant_any_c) begin
      lock_q       <= load_last_c ? LOCK_IDLE : LOCK_HELD;
      lock_owner_q <= grant_idx_c;
      last_q       <= load_last_c;
    end
  end

  assign bus.out_last = last_q;
`else
  logic unused_in_last;

  assign eligible_c     = bus.in_valid;
  assign unused_in_last = ^bus.in_last;
  assign bus.out_last   = 1'b0;
`endif

  // No requests reach the scan while the buffer is full or reset is held.
  assign req_c = (full_q || !clear_n) ? '0 : eligible_c;

  round_robin_select #(
    .INPUT_COUNT  (INPUT_COUNT),
    .SOURCE_WIDTH (SOURCE_WIDTH)
  ) u_select (
    .request     (req_c),
    .last_grant  (last_grant_q),
    .grant       (grant_c),
    .grant_index (grant_idx_c),
    .grant_valid (grant_any_c)
  );

  always_comb begin
    load_word_c = '0;
    for (int unsigned k = 0; k < INPUT_COUNT; k++)
      if (grant_c[k]) load_word_c = bus.in_data[k*WORD_WIDTH +: WORD_WIDTH];
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      full_q       <= 1'b0;
      data_q       <= RESET_VALUE;
      source_q     <= '0;
      last_grant_q <= PTR_RESET;
    end else if (full_q) begin
      if (bus.out_ready) full_q <= 1'b0;
    end else if (grant_any_c) begin
      full_q       <= 1'b1;
      data_q       <= load_word_c;
      source_q     <= grant_idx_c;
      last_grant_q <= grant_idx_c;
    end
  end

  assign bus.in_ready   = grant_c;
  assign bus.out_valid  = full_q;
  assign bus.out_data   = data_q;
  assign bus.out_source = source_q;

endmodule
